demux_rr_dispatcher: RTL

Upstream feeder for the 1-to-8 demultiplexer (inputs d, s0, s1, s2). It accepts a serial 1-bit sample stream through a valid/ready handshake and drives d together with the 3-bit select. Samples are assigned round-robin across an 8-bit channel-enable mask, and each sample is held for a programmable number of cycles. When no sample is being driven, d is forced to 0, so every demux output is 0.

---
 rtl/demux_rr_dispatcher.sv | 117 +++++++++++
 1 files changed

// File: rtl/demux_rr_dispatcher.sv
// Round-robin feeder for a 1-to-8 demux: accepts 1-bit samples over valid/ready,
// drives d plus the 3-bit select, and holds each sample for DWELL cycles.
module demux_rr_dispatcher #(
   parameter int unsigned DWELL = 1,
   parameter int unsigned CW    = 8
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       in_valid,
   input  logic       in_d,
   output logic       in_ready,
   input  logic [7:0] ch_en,
   output logic       d,
   output logic       s0,
   output logic       s1,
   output logic       s2,
   output logic       out_valid,
   output logic       wrap
);

   typedef enum logic {
      IDLE,
      DRIVE
   } state_t;

   // A dwell of 0 behaves like 1: the counter loads 0 and the sample lasts one cycle.
   localparam int unsigned LOAD_INT = (DWELL <= 1) ? 0 : DWELL - 1;
   localparam logic [CW-1:0] LOAD_CNT = LOAD_INT[CW-1:0];

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [2:0]    ptr_q, ptr_d;
   logic [2:0]    sel_q, sel_d;
   logic          data_q, data_d;
   logic          valid_q, valid_d;
   logic          wrap_q, wrap_d;

   logic          accept;
   logic [2:0]    nxt;

   // Lowest offset from ptr+1 wins; offset 8 lands back on ptr itself.
   function automatic logic [2:0] next_channel(input logic [2:0] ptr, input logic [7:0] en);
      logic [2:0] idx;
      next_channel = ptr;
      for (int k = 8; k >= 1; k--) begin
         idx = ptr + 3'(k);
         if (en[idx]) next_channel = idx;
      end
   endfunction

   assign in_ready = (ch_en != 8'h00) && ((state_q == IDLE) || (cnt_q == '0));
   assign accept   = in_valid && in_ready;
   assign nxt      = next_channel(ptr_q, ch_en);

   always_comb begin
      // NOTE: every next-state signal gets a default first, so no path can infer a latch.
      state_d = state_q;
      cnt_d   = cnt_q;
      ptr_d   = ptr_q;
      sel_d   = sel_q;
      data_d  = data_q;
      valid_d = valid_q;
      wrap_d  = 1'b0;

      if (accept) begin
         data_d  = in_d;
         sel_d   = nxt;
         ptr_d   = nxt;
         valid_d = 1'b1;
         cnt_d   = LOAD_CNT;
         state_d = DRIVE;
         wrap_d  = (nxt <= ptr_q);
      end else begin
         case (state_q)
            DRIVE: begin
               if (cnt_q != '0) begin
                  cnt_d = cnt_q - CW'(1);
               end else begin
                  state_d = IDLE;
                  valid_d = 1'b0;
                  data_d  = 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         ptr_q   <= 3'd7;
         sel_q   <= 3'd0;
         data_q  <= 1'b0;
         valid_q <= 1'b0;
         wrap_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         ptr_q   <= ptr_d;
         sel_q   <= sel_d;
         data_q  <= data_d;
         valid_q <= valid_d;
         wrap_q  <= wrap_d;
      end
   end

   assign d         = data_q;
   assign s0        = sel_q[0];
   assign s1        = sel_q[1];
   assign s2        = sel_q[2];
   assign out_valid = valid_q;
   assign wrap      = wrap_q;

endmodule
